// File: rtl/div_8by4.sv
// div_8by4: sequential restoring radix-2 divider, 8-bit dividend / 4-bit divisor.
// One quotient bit per clock, valid/ready handshake on both sides. Overflow
// and divide-by-zero are detected at accept and skip the iteration phase.
module div_8by4 #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       ovf,
    output logic       dz
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [7:0]  dvd;
    logic [3:0]  d;
    logic [3:0]  rem;
    logic [3:0]  q;

    logic        accept;
    logic        pre_dz;
    logic        pre_ovf;
    logic [4:0]  t;
    logic [4:0]  diff;
    logic        ge;
    logic [3:0]  rem_nxt;
    logic [3:0]  q_nxt;

    // Accept decode and overflow pre-check on the live operands. A high
    // nibble >= divisor means the quotient needs more than 4 bits; it also
    // guarantees rem < d for every later iteration.
    always_comb begin
        accept  = in_valid && (state == IDLE);
        pre_dz  = (divisor == 4'd0);
        pre_ovf = pre_dz || (dividend[7:4] >= divisor);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t        = {rem, dvd[cnt]};
        diff     = t - {1'b0, d};
        ge       = (t >= {1'b0, d});
        rem_nxt  = ge ? diff[3:0] : t[3:0];
        q_nxt    = q;
        q_nxt[cnt] = ge;
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = pre_ovf ? DONE : CALC;
            end
            CALC: begin
                if (cnt == 2'd0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration registers and result registers.
    // Results are left untouched on leaving DONE so they stay readable.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt       <= 2'd0;
            dvd       <= 8'd0;
            d         <= 4'd0;
            rem       <= 4'd0;
            q         <= 4'd0;
            quotient  <= 4'd0;
            remainder <= 4'd0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd <= dividend;
                        d   <= divisor;
                        q   <= 4'd0;
                        if (pre_ovf) begin
                            quotient  <= SAT_EN ? 4'hF : 4'h0;
                            remainder <= 4'h0;
                            ovf       <= 1'b1;
                            dz        <= pre_dz;
                        end else begin
                            rem <= dividend[7:4];
                            cnt <= 2'd3;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd0) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt;
                        ovf       <= 1'b0;
                        dz        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_8by4.sv
// tb_div_8by4: directed and exhaustive checks of div_8by4 against an
// arithmetic reference model, with both saturation settings instantiated.
module tb_div_8by4;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       in_valid;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_ready;

    logic       in_ready_1, out_valid_1, ovf_1, dz_1;
    logic [3:0] quotient_1, remainder_1;
    logic       in_ready_0, out_valid_0, ovf_0, dz_0;
    logic [3:0] quotient_0, remainder_0;

    int n_chk  = 0;
    int n_fail = 0;

    div_8by4 #(.SAT_EN(1'b1)) u_sat1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(in_ready_1),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid_1), .out_ready(out_ready),
        .quotient(quotient_1), .remainder(remainder_1),
        .ovf(ovf_1), .dz(dz_1)
    );

    div_8by4 #(.SAT_EN(1'b0)) u_sat0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .in_valid(in_valid), .in_ready(in_ready_0),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid_0), .out_ready(out_ready),
        .quotient(quotient_0), .remainder(remainder_0),
        .ovf(ovf_0), .dz(dz_0)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 computing, 2 result held.
    int         m_phase = 0;
    int         m_left  = 0;
    int         p_q, p_r;
    int         m_q1 = 0, m_q0 = 0, m_r = 0, m_ov = 0, m_dz = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_phase = 0; m_left = 0;
            m_q1 = 0; m_q0 = 0; m_r = 0; m_ov = 0; m_dz = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    int a, b;
                    a = dividend;
                    b = divisor;
                    if (b == 0 || a / b > 15) begin
                        m_q1 = 15; m_q0 = 0; m_r = 0; m_ov = 1;
                        m_dz = (b == 0) ? 1 : 0;
                        m_phase = 2;
                    end else begin
                        p_q = a / b;
                        p_r = a % b;
                        m_left = 4;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_q1 = p_q; m_q0 = p_q; m_r = p_r; m_ov = 0; m_dz = 0;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge sys_clk) begin
        chk("in_ready_1",  in_ready_1,  m_phase == 0);
        chk("in_ready_0",  in_ready_0,  m_phase == 0);
        chk("out_valid_1", out_valid_1, m_phase == 2);
        chk("out_valid_0", out_valid_0, m_phase == 2);
        chk("quotient_1",  quotient_1,  m_q1);
        chk("quotient_0",  quotient_0,  m_q0);
        chk("remainder_1", remainder_1, m_r);
        chk("remainder_0", remainder_0, m_r);
        chk("ovf_1", ovf_1, m_ov);
        chk("ovf_0", ovf_0, m_ov);
        chk("dz_1",  dz_1,  m_dz);
        chk("dz_0",  dz_0,  m_dz);
    end

    // Issue one division with out_ready high and return once out_valid is seen.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, output int lat);
        @(negedge sys_clk);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid_1) break;
        end
        if (!out_valid_1) chk("timeout_out_valid", 0, 1);
    endtask

    task automatic run(input string nm, input logic [7:0] a, input logic [3:0] b,
                       input int eq1, input int eq0, input int er,
                       input int eov, input int edz, input int elat);
        int lat;
        issue(a, b, lat);
        chk({nm, "_lat"}, lat, elat);
        chk({nm, "_q1"},  quotient_1, eq1);
        chk({nm, "_q0"},  quotient_0, eq0);
        chk({nm, "_r"},   remainder_1, er);
        chk({nm, "_ovf"}, ovf_1, eov);
        chk({nm, "_dz"},  dz_1, edz);
    endtask

    initial begin
        int lat;
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        dividend  = 8'd0;
        divisor   = 4'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready_1, 1);
        chk("rst_out_valid", out_valid_1, 0);
        chk("rst_q", quotient_1, 0);
        chk("rst_ovf", ovf_1, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Accept counts as edge 1: normal results after 5 edges, overflow after 1.
        run("inv143_11", 8'd143, 4'd11, 13, 13, 0, 0, 0, 5);
        run("r200_13",   8'd200, 4'd13, 15, 15, 5, 0, 0, 5);
        run("ovf240_15", 8'd240, 4'd15, 15, 0, 0, 1, 0, 1);
        run("dz7_0",     8'd7,   4'd0,  15, 0, 0, 1, 1, 1);
        run("r0_5",      8'd0,   4'd5,  0,  0, 0, 0, 0, 5);
        run("r255_1",    8'd255, 4'd1,  15, 0, 0, 1, 0, 1);
        run("r15_1",     8'd15,  4'd1,  15, 15, 0, 0, 0, 5);
        run("r239_15",   8'd239, 4'd15, 15, 15, 14, 0, 0, 5);

        // Backpressure: result must hold and new operands must be refused.
        @(negedge sys_clk);
        out_ready = 1'b0;
        dividend  = 8'd100;
        divisor   = 4'd7;
        in_valid  = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8 && !out_valid_1; i++) @(negedge sys_clk);
        chk("bp_valid_rise", out_valid_1, 1);
        for (int i = 0; i < 10; i++) begin
            dividend = 8'd50;
            divisor  = 4'd3;
            in_valid = i[0];
            @(negedge sys_clk);
            chk("bp_valid_hold", out_valid_1, 1);
            chk("bp_q_hold", quotient_1, 14);
            chk("bp_r_hold", remainder_1, 2);
            chk("bp_in_ready", in_ready_1, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge sys_clk);
        chk("bp_release_valid", out_valid_1, 0);
        chk("bp_release_ready", in_ready_1, 1);
        chk("bp_q_kept", quotient_1, 14);

        // Reset two cycles after accept aborts the division.
        @(negedge sys_clk);
        dividend = 8'd143;
        divisor  = 4'd11;
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready_1, 1);
        chk("mid_rst_valid", out_valid_1, 0);
        chk("mid_rst_q", quotient_1, 0);
        chk("mid_rst_r", remainder_1, 0);
        chk("mid_rst_ovf", ovf_1, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            chk("post_rst_no_valid", out_valid_1, 0);
        end

        // Exhaustive sweep: identity for normal results, overflow rule otherwise.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a[7:0], b[3:0], lat);
                if (ovf_1) begin
                    chk("sweep_ovf_rule", (b == 0) || (a / b > 15), 1);
                end else begin
                    chk("sweep_identity", quotient_1 * b + remainder_1, a);
                    chk("sweep_rem_lt", remainder_1 < b, 1);
                end
            end
        end

        @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_8by4.md
# div_8by4

Sequential unsigned divider: 8-bit dividend by 4-bit divisor, giving a 4-bit quotient and a 4-bit remainder. It is the inverse datapath to the team's 4x4 LUT/carry-chain multiplier. It recovers one 4-bit operand from an 8-bit product and the other operand, for calibration back-calculation in the detector pipeline. It uses a restoring, radix-2 algorithm, one quotient bit per clock, with valid/ready handshakes on both sides.

## Interface
- SAT_EN, 1: on overflow or divide-by-zero, quotient = 4'hF if 1, 4'h0 if 0.
- sys_clk  in  1  single clock, all state on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- dividend  in  8  unsigned dividend, sampled on accept.
- divisor  in  4  unsigned divisor, sampled on accept.
- out_valid  out  1  result valid, held until taken.
- out_ready  in  1  downstream accepts result.
- quotient  out  4  unsigned quotient.
- remainder  out  4  unsigned remainder.
- ovf  out  1  quotient does not fit in 4 bits, or divisor == 0.
- dz  out  1  divisor == 0 (implies ovf).

## Operation
- Clock and reset: one clock, sys_clk. sys_rst_n is asynchronous and active-low.
- States:
  - IDLE: in_ready=1.
  - CALC: 4 iterations, counter cnt counts 3→0.
  - DONE: out_valid=1.
- Accept: an accept occurs on an edge where in_valid & in_ready.
  - Latch dividend into dvd and divisor into d. Clear the quotient register.
- Overflow check, done at accept from the live inputs:
  - dz = (divisor == 0).
  - ovf = dz | (dividend[7:4] >= divisor).
  - If ovf: go straight to DONE. Quotient = SAT_EN ? 4'hF : 4'h0, remainder = 4'h0, ovf=1, dz as computed.
  - Else: set rem = dividend[7:4], cnt = 3, go to CALC.
- CALC iteration i = cnt:
  - t = {rem, dvd[i]}, 5 bits.
  - If t >= {1'b0,d}: rem = (t − d)[3:0] and q[i] = 1.
  - Else: rem = t[3:0] and q[i] = 0.
  - When cnt == 0: load quotient = q and remainder = rem, clear ovf and dz, go to DONE.
- rem always stays < d, so 4 bits suffice; the invariant holds because the pre-check guarantees dividend[7:4] < d.
- DONE:
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0.
  - The edge with out_valid & out_ready goes to IDLE.
  - quotient, remainder, ovf and dz keep their last values after leaving DONE; only out_valid drops.
- No overlap: in_valid is ignored outside IDLE, and operands are not queued.
- Result identity for non-overflow cases: dividend == quotient*divisor + remainder, with remainder < divisor.

## Timing
- Reset (asynchronous, takes effect immediately): state=IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, ovf=0, dz=0; internal cnt, rem, q cleared.
- Reset mid-CALC or mid-DONE: the operation is aborted and its result is lost. There is no out_valid pulse after reset release.
- Normal latency:
  - Accept edge E0. CALC edges E1..E4. out_valid high after E4, i.e. 4 cycles after accept.
  - in_ready is low from the cycle after E0 until return to IDLE.
- Overflow and divide-by-zero latency: out_valid high after E0, i.e. 1 cycle.
- Throughput with out_ready tied high:
  - Result taken at E5, IDLE in the following cycle, next accept at E6 at earliest.
  - One division per 6 cycles.
- out_ready asserted before out_valid has no effect. in_ready/in_valid and out_valid/out_ready are independent. in_valid may stay high across operations; a new accept happens only in IDLE.

## Test plan
- Exact inverse of multiplier product: dividend=8'd143, divisor=4'd11 → after 4 cycles quotient=13, remainder=0, ovf=0, dz=0.
- Non-zero remainder: 8'd200 / 4'd13 → quotient=15, remainder=5, ovf=0. Also run an exhaustive sweep of all 4096 operand pairs, checking the identity or the overflow rule against a reference model.
- Overflow: 8'd240 / 4'd15 → out_valid after 1 cycle, ovf=1, dz=0, quotient=4'hF (SAT_EN=1), remainder=0. Repeat with SAT_EN=0 → quotient=4'h0.
- Divide by zero: 8'd7 / 4'd0 → after 1 cycle ovf=1, dz=1, quotient=4'hF.
- Backpressure: 8'd100 / 4'd7, with out_ready held low 10 cycles and in_valid pulsed with other operands during that time. Required response:
  - out_valid stays 1 and quotient=14, remainder=2 stay stable.
  - in_ready stays 0 and the second operands are not accepted.
  - Raising out_ready → IDLE next cycle.
- Reset mid-CALC: assert sys_rst_n=0 two cycles after accepting 8'd143 / 4'd11 → all outputs 0 immediately and in_ready=1. After release, no out_valid appears without a new accept.
